// File: rtl/wb_fifo_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo_slave
// Description : Wishbone B4 classic slave: DATA pushes into a FIFO drained by
//               a valid/ready stream; STATUS/CTRL expose occupancy and flush.
//               Optional macro WB_FIFO_SLAVE_STALL_EN stalls full-FIFO writes.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo_slave #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic [7:0]            sel_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i
);

    localparam int SEL_WIDTH = 8;
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESP  = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

`ifdef WB_FIFO_SLAVE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic [1:0]            state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];

    logic                  req, full, empty, sel_ok, pop;
    logic                  dec_push, dec_ack, dec_err, dec_stall;
    logic                  dec_flush, dec_clr_ovf, dec_set_ovf;
    logic [DATA_WIDTH-1:0] rd_val, status;
    logic                  unused_bits;

    assign req       = cyc_i & stb_i;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign sel_ok    = &sel_i[BYTES-1:0];
    assign m_valid_o = ~empty;
    assign m_data_o  = fifo_mem[rd_ptr_q];
    assign pop       = m_valid_o & m_ready_i;

    assign unused_bits = ^{adr_i[ADDR_WIDTH-1:4], adr_i[1:0], sel_i[SEL_WIDTH-1:BYTES]};

    always_comb begin
        status        = '0;
        status[15:0]  = 16'(count_q);
        status[16]    = empty;
        status[17]    = full;
        status[18]    = ovf_q;
    end

    // Access decision, shared by IDLE and the STALL retry loop.
    always_comb begin
        dec_push    = 1'b0;
        dec_ack     = 1'b0;
        dec_err     = 1'b0;
        dec_stall   = 1'b0;
        dec_flush   = 1'b0;
        dec_clr_ovf = 1'b0;
        dec_set_ovf = 1'b0;
        rd_val      = '0;
        if (req && (state_q == S_IDLE || state_q == S_STALL)) begin
            case (adr_i[3:2])
                REG_DATA: begin
                    if (!we_i || !sel_ok) begin
                        dec_err = 1'b1;
                    end else if (full) begin
                        if (STALL_EN) begin
                            dec_stall = 1'b1;
                        end else begin
                            dec_err     = 1'b1;
                            dec_set_ovf = 1'b1;
                        end
                    end else begin
                        dec_push = 1'b1;
                        dec_ack  = 1'b1;
                    end
                end
                REG_STATUS: begin
                    if (we_i) begin
                        dec_err = 1'b1;
                    end else begin
                        dec_ack = 1'b1;
                        rd_val  = status;
                    end
                end
                REG_CTRL: begin
                    dec_ack = 1'b1;
                    if (we_i) begin
                        dec_flush   = dat_i[0];
                        dec_clr_ovf = dat_i[1];
                    end
                end
                default: dec_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = dec_stall ? S_STALL : S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_STALL: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (!dec_stall) begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack_d = dec_ack;
        err_d = dec_err;
        dat_d = dec_ack ? rd_val : '0;
    end

    // Flush takes priority over a concurrent pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (dec_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (dec_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(dec_push) - CNT_W'(pop);
        end
        if (dec_clr_ovf) begin
            ovf_d = 1'b0;
        end else if (dec_set_ovf) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            dat_q    <= dat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && dec_push) begin
            fifo_mem[wr_ptr_q] <= dat_i;
        end
    end

    assign ack_o = ack_q;
    assign err_o = err_q;
    assign dat_o = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_fifo_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_fifo_slave
// Description : Directed vector bench for wb_fifo_slave (register map, FIFO
//               stream, overflow, flush). Honours WB_FIFO_SLAVE_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_fifo_slave;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i  = 1'b0;
    logic [15:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [7:0]  sel_i = '0;
    logic        ack_o, err_o, m_valid_o;
    logic [31:0] dat_o, m_data_o;
    logic        m_ready_i = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    wb_fifo_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i), .ack_o(ack_o), .err_o(err_o),
        .dat_o(dat_o), .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i)
    );

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [31:0] dat;
        logic [7:0]  sel;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One access; mr drives m_ready_i for the decision cycle only.
    task automatic wb_xfer(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                           input logic [7:0] sel, input logic mr,
                           output logic ack, output logic err, output logic [31:0] rdat,
                           output int lat);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
        m_ready_i = mr;
        ack = 1'b0; err = 1'b0; rdat = '0; lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk_i); #1;
            m_ready_i = 1'b0;
            if (ack_o || err_o) begin
                ack = ack_o; err = err_o; rdat = dat_o; lat = c;
                break;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i); #1;
        chk("pulse_width", 32'(ack_o | err_o), 32'd0);
    endtask

    task automatic do_xfer(input string name, input logic we, input logic [15:0] adr,
                           input logic [31:0] dat, input logic mr,
                           input logic e_ack, input logic e_err, input logic [31:0] e_dat);
        logic a, e;
        logic [31:0] r;
        int l;
        wb_xfer(we, adr, dat, 8'hFF, mr, a, e, r, l);
        chk({name, "_ack"}, 32'(a), 32'(e_ack));
        chk({name, "_err"}, 32'(e), 32'(e_err));
        chk({name, "_dat"}, r, e_dat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        a, e, busy, got;
        logic [31:0] r;
        int          l;

        //             we    adr       dat           sel    ack   err   dat_o
        tv[0]  = '{1'b0, 16'h0004, 32'h0,        8'hFF, 1'b1, 1'b0, 32'h0001_0000};
        tv[1]  = '{1'b1, 16'h0000, 32'hDEADBEEF, 8'hFF, 1'b1, 1'b0, 32'h0};
        tv[2]  = '{1'b1, 16'h0010, 32'h12345678, 8'h0F, 1'b1, 1'b0, 32'h0};
        tv[3]  = '{1'b0, 16'h0004, 32'h0,        8'hFF, 1'b1, 1'b0, 32'h0000_0002};
        tv[4]  = '{1'b0, 16'h0000, 32'h0,        8'hFF, 1'b0, 1'b1, 32'h0};
        tv[5]  = '{1'b1, 16'h0004, 32'hFFFFFFFF, 8'hFF, 1'b0, 1'b1, 32'h0};
        tv[6]  = '{1'b0, 16'h000C, 32'h0,        8'hFF, 1'b0, 1'b1, 32'h0};
        tv[7]  = '{1'b1, 16'h000C, 32'h3,        8'hFF, 1'b0, 1'b1, 32'h0};
        tv[8]  = '{1'b1, 16'h0000, 32'hCAFEF00D, 8'hF0, 1'b0, 1'b1, 32'h0};
        tv[9]  = '{1'b1, 16'h0000, 32'hCAFEF00D, 8'h0E, 1'b0, 1'b1, 32'h0};
        tv[10] = '{1'b0, 16'h0008, 32'h0,        8'hFF, 1'b1, 1'b0, 32'h0};
        tv[11] = '{1'b0, 16'h0014, 32'h0,        8'hFF, 1'b1, 1'b0, 32'h0000_0002};

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_valid", 32'(m_valid_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 12; i++) begin
            wb_xfer(tv[i].we, tv[i].adr, tv[i].dat, tv[i].sel, 1'b0, a, e, r, l);
            chk($sformatf("vec%0d_ack", i), 32'(a), 32'(tv[i].exp_ack));
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(tv[i].exp_err));
            chk($sformatf("vec%0d_dat", i), r, tv[i].exp_dat);
            chk($sformatf("vec%0d_latency", i), 32'(l), 32'd1);
        end

        // Stream drain: two words, consumer ready for two cycles.
        @(negedge clk_i);
        chk("head_valid", 32'(m_valid_o), 32'd1);
        chk("head_data", m_data_o, 32'hDEADBEEF);
        m_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("second_valid", 32'(m_valid_o), 32'd1);
        chk("second_data", m_data_o, 32'h12345678);
        @(posedge clk_i); #1;
        chk("drained_valid", 32'(m_valid_o), 32'd0);
        @(negedge clk_i);
        m_ready_i = 1'b0;

        // Fill to DEPTH, then one write too many.
        for (int i = 0; i < 8; i++) begin
            do_xfer($sformatf("fill%0d", i), 1'b1, 16'h0000, 32'h1000_0000 + i, 1'b0, 1'b1, 1'b0, 32'h0);
        end
        chk("full_head", m_data_o, 32'h1000_0000);
        do_xfer("status_full", 1'b0, 16'h0004, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0002_0008);
`ifdef WB_FIFO_SLAVE_STALL_EN
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h0000; dat_i = 32'hBAD0BAD0; sel_i = 8'hFF;
        busy = 1'b0;
        repeat (5) begin
            @(posedge clk_i); #1;
            if (ack_o || err_o) busy = 1'b1;
        end
        chk("stall_hold", 32'(busy), 32'd0);
        @(negedge clk_i);
        m_ready_i = 1'b1;
        @(posedge clk_i); #1;
        m_ready_i = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i); #1;
            if (ack_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("stall_ack", 32'(got), 32'd1);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i); #1;
        do_xfer("status_stall", 1'b0, 16'h0004, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0002_0008);
`else
        do_xfer("overflow_wr", 1'b1, 16'h0000, 32'hBAD0BAD0, 1'b0, 1'b0, 1'b1, 32'h0);
        do_xfer("status_ovf", 1'b0, 16'h0004, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0006_0008);
        chk("ovf_head", m_data_o, 32'h1000_0000);
`endif
        do_xfer("clr_ovf", 1'b1, 16'h0008, 32'h2, 1'b0, 1'b1, 1'b0, 32'h0);
        do_xfer("status_clr", 1'b0, 16'h0004, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0002_0008);

        // Flush, push three, then flush again racing a pop.
        do_xfer("flush1", 1'b1, 16'h0008, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("flush1_valid", 32'(m_valid_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            do_xfer($sformatf("push3_%0d", i), 1'b1, 16'h0000, 32'h3000_0000 + i, 1'b0, 1'b1, 1'b0, 32'h0);
        end
        do_xfer("status3", 1'b0, 16'h0004, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_0003);
        do_xfer("flush_pop", 1'b1, 16'h0008, 32'h1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("flush_pop_valid", 32'(m_valid_o), 32'd0);
        do_xfer("status_flushed", 1'b0, 16'h0004, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0001_0000);
        do_xfer("push_a5", 1'b1, 16'h0000, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("flush_ptr_head", m_data_o, 32'hA5A5A5A5);

        // Simultaneous push and pop keeps the count.
        do_xfer("push_pop", 1'b1, 16'h0000, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("push_pop_head", m_data_o, 32'h5A5A5A5A);
        do_xfer("status_pp", 1'b0, 16'h0004, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_0001);

        // Reset during a write discards it.
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h0000; dat_i = 32'h77777777; sel_i = 8'hFF;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_mid_ack", 32'(ack_o | err_o), 32'd0);
        chk("rst_mid_valid", 32'(m_valid_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        do_xfer("status_rst", 1'b0, 16'h0004, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0001_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
